// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch-stage controller between the PC, instruction memory and decode.
// Optional performance counters are built only when IF_PERF_EN is defined.
`default_nettype none

module instruction_fetch (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_count,
  output logic        pc_countEn,
  output logic [31:0] pc_next_count,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_FETCH  = 2'd1;
  localparam logic [1:0] C_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_npc;

  logic        w_accept;
  logic        w_fetch;
  logic        w_redirect;
  logic        w_load;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_count + 32'd4;
  assign w_accept   = !r_valid || if_ready;
  assign w_fetch    = (r_state == C_FETCH);

  // Halt outranks redirect, and redirect outranks any same-cycle hit.
  assign w_redirect = w_fetch && !halt && redirect;
  assign imemREN    = w_fetch && w_accept;
  assign w_load     = imemREN && ihit && !halt && !redirect;

  assign pc_countEn    = w_redirect || w_load;
  assign pc_next_count = w_redirect ? {redirect_addr[31:2], 2'b00} : w_pc_plus4;
  assign imemaddr      = pc_count;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE:   w_state_next = halt ? C_HALTED : C_FETCH;
      C_FETCH:  w_state_next = halt ? C_HALTED : C_FETCH;
      C_HALTED: w_state_next = C_HALTED;
      default:  w_state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= C_IDLE;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_npc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_redirect) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if (if_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_instr <= imemload;
        r_pc    <= pc_count;
        r_npc   <= w_pc_plus4;
      end
    end
  end

  assign if_valid = r_valid;
  assign if_instr = r_instr;
  assign if_pc    = r_pc;
  assign if_npc   = r_npc;

`ifdef IF_PERF_EN
  logic [31:0] r_fetches;
  logic [31:0] r_stalls;

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetches <= '0;
      r_stalls  <= '0;
    end else begin
      if (w_load && (r_fetches != 32'hFFFF_FFFF)) begin
        r_fetches <= r_fetches + 32'd1;
      end
      if (imemREN && !ihit && (r_stalls != 32'hFFFF_FFFF)) begin
        r_stalls <= r_stalls + 32'd1;
      end
    end
  end

  assign perf_fetches = r_fetches;
  assign perf_stalls  = r_stalls;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed, table-driven bench for instruction_fetch.
`default_nettype none

module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        ren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;

  int tests = 0;
  int fails = 0;

  instruction_fetch dut (
    .CLK           (clk),
    .RST           (rst),
    .pc_count      (pc),
    .pc_countEn    (pc_en),
    .pc_next_count (pc_next),
    .imemREN       (ren),
    .imemaddr      (iaddr),
    .imemload      (iload),
    .ihit          (ihit),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_npc        (if_npc),
    .perf_fetches  (perf_fetches),
    .perf_stalls   (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter and address-derived memory contents.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else if (pc_en) pc <= pc_next;
  end
  assign iload = iaddr + 32'h1000_0000;

  typedef struct {
    logic        ihit;
    logic        rdy;
    logic        redir;
    logic [31:0] raddr;
    logic [31:0] addr;
    logic        ren;
    logic        en;
    logic [31:0] nxt;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[16];

`ifdef IF_PERF_EN
  localparam logic [31:0] EXP_FETCHES = 32'd8;
  localparam logic [31:0] EXP_STALLS  = 32'd3;
`else
  localparam logic [31:0] EXP_FETCHES = 32'd0;
  localparam logic [31:0] EXP_STALLS  = 32'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            ihit  rdy   redir raddr          addr           ren   en    nxt            vld   ipc            instr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'h0,         32'h1000_0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4,         32'h1000_0004};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h8,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8,         32'h1000_0008};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h40,        32'hC,         1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h40,        1'b1, 1'b0, 32'h44,        1'b0, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h40,        1'b1, 1'b0, 32'h44,        1'b0, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h40,        1'b1, 1'b0, 32'h44,        1'b0, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h40,        1'b1, 1'b1, 32'h44,        1'b1, 32'h40,        32'h1000_0040};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h44,        1'b0, 1'b0, 32'h48,        1'b1, 32'h40,        32'h1000_0040};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h44,        1'b0, 1'b0, 32'h48,        1'b1, 32'h40,        32'h1000_0040};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h44,        1'b1, 1'b1, 32'h48,        1'b1, 32'h44,        32'h1000_0044};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h48,        1'b1, 1'b1, 32'h4C,        1'b1, 32'h48,        32'h1000_0048};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h107,       32'h4C,        1'b1, 1'b1, 32'h104,       1'b0, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h104,       1'b1, 1'b1, 32'h108,       1'b1, 32'h104,       32'h1000_0104};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h108,       1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0FFF_FFFC};

    rst = 1'b1; ihit = 1'b0; if_ready = 1'b0; redirect = 1'b0;
    redirect_addr = 32'h0; halt = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_npc", if_npc, 32'h0);
    check("rst_ren", {31'd0, ren}, 32'd0);
    check("rst_en", {31'd0, pc_en}, 32'd0);
    check("rst_next", pc_next, 32'h4);
    check("rst_perf_f", perf_fetches, 32'h0);
    check("rst_perf_s", perf_stalls, 32'h0);

    // Leave reset: one IDLE cycle with no request
    rst = 1'b0; ihit = 1'b1; if_ready = 1'b1;
    #1;
    check("idle_ren", {31'd0, ren}, 32'd0);
    check("idle_en", {31'd0, pc_en}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ihit = vecs[i].ihit; if_ready = vecs[i].rdy;
      redirect = vecs[i].redir; redirect_addr = vecs[i].raddr;
      #1;
      check($sformatf("v%0d_addr", i), iaddr, vecs[i].addr);
      check($sformatf("v%0d_ren", i), {31'd0, ren}, {31'd0, vecs[i].ren});
      check($sformatf("v%0d_en", i), {31'd0, pc_en}, {31'd0, vecs[i].en});
      check($sformatf("v%0d_next", i), pc_next, vecs[i].nxt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].vld});
      if (vecs[i].vld) begin
        check($sformatf("v%0d_ipc", i), if_pc, vecs[i].ipc);
        check($sformatf("v%0d_instr", i), if_instr, vecs[i].instr);
        check($sformatf("v%0d_npc", i), if_npc, vecs[i].ipc + 32'd4);
      end
    end

    @(negedge clk);
    redirect = 1'b0;
    check("perf_fetches", perf_fetches, EXP_FETCHES);
    check("perf_stalls", perf_stalls, EXP_STALLS);

    // Halt together with redirect while decode is stalled
    halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h200; ihit = 1'b1; if_ready = 1'b0;
    #1;
    check("halt_en", {31'd0, pc_en}, 32'd0);
    check("halt_ren", {31'd0, ren}, 32'd0);
    @(posedge clk); #1;
    check("halt_hold_valid", {31'd0, if_valid}, 32'd1);
    check("halt_hold_pc", if_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    halt = 1'b0; if_ready = 1'b1;
    #1;
    check("halted_ren", {31'd0, ren}, 32'd0);
    check("halted_en", {31'd0, pc_en}, 32'd0);
    @(posedge clk); #1;
    check("halted_drain", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      redirect = i[0];
      #1;
      check($sformatf("halted%0d_ren", i), {31'd0, ren}, 32'd0);
      check($sformatf("halted%0d_en", i), {31'd0, pc_en}, 32'd0);
    end
    check("halted_pc", pc, 32'h0);

    // Only reset leaves HALTED
    @(negedge clk);
    redirect = 1'b0; rst = 1'b1;
    #1;
    check("rst2_ren", {31'd0, ren}, 32'd0);
    check("rst2_perf_f", perf_fetches, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_idle_ren", {31'd0, ren}, 32'd0);
    @(negedge clk); #1;
    check("rst2_fetch_ren", {31'd0, ren}, 32'd1);
    check("rst2_fetch_addr", iaddr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
